multicycle_ctrl: RTL
====================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It decodes the registered instruction fields and sequences PC, instruction register, register file, ALU, memory port and immediate generator over several cycles per instruction. It drives the `ImmSrc` select of the immediate generator and every datapath mux select and write strobe. Supported subset: add, addi, lbu, sb, bne, bgeu, jal, jalr, lui. Anything else traps.

## Interface
Parameters: none. All encodings are fixed in `ctrl_pkg`.

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `op`  in  7  `IR[6:0]`
- `funct3`  in  3  `IR[14:12]`
- `funct7b5`  in  1  `IR[30]`
- `zero`  in  1  ALU result == 0 (from the compare subtract)
- `ltu`  in  1  unsigned rs1 < rs2 (from the compare subtract)
- `mem_ready`  in  1  memory completes the current request this cycle
- `mem_req`  out  1  memory access request
- `mem_write`  out  1  store strobe, qualifies `mem_req`
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR and OldPC
- `pc_write`  out  1  load PC from the result bus
- `reg_write`  out  1  register file write
- `result_src`  out  2  result bus select: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- `alu_src_b`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = 4
- `alu_ctrl`  out  3  ALU operation: 000 = add, 001 = sub
- `imm_src`  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  sticky trap flag

## Operation
States and transitions:
- FETCH: `mem_req`=1, `adr_src`=0, A=PC, B=4, add, `result_src`=10. While `mem_ready`=0 the FSM stays in FETCH with `ir_write` and `pc_write` both 0. When `mem_ready`=1, `ir_write` and `pc_write` are asserted for that cycle, then go to DECODE.
- DECODE: A=OldPC, B=Imm, add (branch/jal target into ALUOut). Next state by opcode:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - 0110111 → LUI
  - unsupported opcode, or unsupported funct3/funct7b5 → ILLEGAL
- MEMADR: A=RD1, B=Imm, add. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Waits for `mem_ready`, then → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1, `instr_done`=1, → FETCH.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, held until `mem_ready`. `instr_done`=1 in the ready cycle, → FETCH.
- EXEC_R: A=RD1, B=RD2, `alu_ctrl` from `alu_dec`, → ALUWB.
- EXEC_I: A=RD1, B=Imm, add, → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1, `instr_done`=1, → FETCH.
- BRANCH: A=RD1, B=RD2, sub, `result_src`=00.
  - `pc_write` = taken, where taken = bne ? !`zero` : !`ltu` (bgeu).
  - `instr_done`=1, → FETCH.
- JALR_ADR: A=RD1, B=Imm, add, → JAL.
- JAL: A=OldPC, B=4, add, `result_src`=00, `pc_write`=1, → ALUWB (writes OldPC+4 to rd).
- LUI: `result_src`=11, `reg_write`=1, `instr_done`=1, → FETCH.
- ILLEGAL: all strobes 0, `illegal`=1. Terminal until reset.

Decode rules:
- `imm_src` is combinational from `op` in every state: load/jalr/op-imm → I, store → S, branch → B, lui → U, jal → J, otherwise 000.
- Legal funct3 values:
  - R-type: funct3=000 with funct7b5=0
  - addi: 000
  - lbu: 100
  - sb: 000
  - bne: 001
  - bgeu: 111
  - jalr: 000
- Mux selects not listed for a state are don't-care. Strobes not listed for a state are 0.

## Timing
- All outputs are Moore-decoded from state, plus `mem_ready` (FETCH/MEMWRITE) and `zero`/`ltu` (BRANCH) within the same cycle.
- Reset:
  - `rst_n` low forces state to FETCH immediately and clears `illegal`.
  - While `rst_n` is low, `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write` and `instr_done` are all 0.
  - After release, outputs take FETCH values.
  - A reset asserted mid-instruction abandons it with no writeback.
- Latency with `mem_ready` tied high: branch/lui 3 cycles; R/I/store/jal 4; load/jalr 5.
- Each cycle of `mem_ready`=0 in a memory state adds exactly one cycle.

## Structure
- `ctrl_pkg`: state enum, opcode localparams, ImmSrc encodings, ResultSrc/ALUSrcA/ALUSrcB encodings, ALU op encodings.
- Sub-module `alu_dec`: combinational map (state class, funct3, funct7b5) → `alu_ctrl` plus a funct-legality flag.

## Test plan
- Reset release, then `op`=0110011, `funct3`=000, `funct7b5`=0, `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALUWB; `reg_write`=1 only in cycle 4; `instr_done` pulses once.
- lbu (`op`=0000011, `funct3`=100) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `result_src`=01 and `reg_write`=1 in MEMWB.
- Branches:
  - bne with `zero`=0 → `pc_write`=1 in BRANCH.
  - bne with `zero`=1 → `pc_write`=0.
  - bgeu with `ltu`=1 → `pc_write`=0.
  - All complete in 3 cycles.
- jalr → JALR_ADR then JAL with `pc_write`=1, `alu_src_a`=01, `alu_src_b`=10; ALUWB `reg_write`=1; `imm_src`=000 throughout.
- `op`=0110011 with `funct7b5`=1 → ILLEGAL; `illegal`=1 held for 10 cycles with all strobes 0; `rst_n` pulse clears it to FETCH.
- `rst_n` asserted during MEMWRITE with `mem_ready`=0 → `mem_write`/`mem_req` drop the same cycle; state is FETCH after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: state codes,
// opcodes, immediate formats, datapath mux selects and ALU operations.
package ctrl_pkg;

    // FSM state codes
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JALR_ADR = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_ILLEGAL  = 4'd13;

    // Opcodes of the supported subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Immediate generator formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // What kind of ALU operation the current state wants
    typedef enum logic [1:0] {
        ALU_CLASS_ADD   = 2'b00,
        ALU_CLASS_SUB   = 2'b01,
        ALU_CLASS_FUNCT = 2'b10
    } alu_class_e;

    // Immediate format implied by the opcode, independent of state
    function automatic logic [2:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_JALR, OP_I: imm_src_for = IMM_I;
            OP_STORE:               imm_src_for = IMM_S;
            OP_BRANCH:              imm_src_for = IMM_B;
            OP_LUI:                 imm_src_for = IMM_U;
            OP_JAL:                 imm_src_for = IMM_J;
            default:                imm_src_for = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the requested ALU class and instruction function bits
// to an ALU operation, and flags whether op/funct3/funct7b5 form a
// supported instruction.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl,
    output logic       funct_legal
);

    // ALU operation select; only add exists among R-type, so anything else traps earlier
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_class)
            ALU_CLASS_SUB:   alu_ctrl = ALU_SUB;
            ALU_CLASS_FUNCT: alu_ctrl = ALU_ADD;
            default:         alu_ctrl = ALU_ADD;
        endcase
    end

    // Legality of the function fields for each supported opcode
    always_comb begin
        funct_legal = 1'b0;
        case (op)
            OP_R:      funct_legal = (funct3 == 3'b000) && !funct7b5;
            OP_I:      funct_legal = (funct3 == 3'b000);
            OP_LOAD:   funct_legal = (funct3 == 3'b100);
            OP_STORE:  funct_legal = (funct3 == 3'b000);
            OP_BRANCH: funct_legal = (funct3 == 3'b001) || (funct3 == 3'b111);
            OP_JALR:   funct_legal = (funct3 == 3'b000);
            OP_JAL:    funct_legal = 1'b1;
            OP_LUI:    funct_legal = 1'b1;
            default:   funct_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback for the supported subset and traps on
// anything else. Outputs are Moore-decoded from the state, with mem_ready
// and the branch flags folded in combinationally where needed.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic [1:0] alu_class;
    logic       funct_legal;
    logic       branch_taken;

    // Ungated strobes; reset forces them low at the ports
    logic mem_req_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic pc_write_raw;
    logic reg_write_raw;
    logic instr_done_raw;

    alu_dec u_alu_dec (
        .alu_class   (alu_class),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_ctrl    (alu_ctrl),
        .funct_legal (funct_legal)
    );

    assign imm_src      = imm_src_for(op);
    assign branch_taken = (funct3 == 3'b001) ? !zero : !ltu;
    assign illegal      = (state_reg == S_ILLEGAL);

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (!funct_legal) begin
                    state_next = S_ILLEGAL;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXEC_R;
                        OP_I:              state_next = S_EXEC_I;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR_ADR;
                        OP_LUI:            state_next = S_LUI;
                        default:           state_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC_R:   state_next = S_ALUWB;
            S_EXEC_I:   state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JALR_ADR: state_next = S_JAL;
            S_JAL:      state_next = S_ALUWB;
            S_LUI:      state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    // Per-state datapath selects and strobes
    always_comb begin
        mem_req_raw    = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        pc_write_raw   = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        adr_src        = 1'b0;
        result_src     = RES_ALUOUT;
        alu_src_a      = SRCA_PC;
        alu_src_b      = SRCB_RD2;
        alu_class      = ALU_CLASS_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req_raw  = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR, S_EXEC_I, S_JALR_ADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src     = RES_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw    = 1'b1;
                mem_write_raw  = 1'b1;
                adr_src        = 1'b1;
                instr_done_raw = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                alu_class = ALU_CLASS_FUNCT;
            end
            S_ALUWB: begin
                result_src     = RES_ALUOUT;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a      = SRCA_RD1;
                alu_src_b      = SRCB_RD2;
                alu_class      = ALU_CLASS_SUB;
                result_src     = RES_ALUOUT;
                pc_write_raw   = branch_taken;
                instr_done_raw = 1'b1;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALUOUT;
                pc_write_raw = 1'b1;
            end
            S_LUI: begin
                result_src     = RES_IMMEXT;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Hold every strobe low while reset is asserted
    assign mem_req    = rst_n & mem_req_raw;
    assign mem_write  = rst_n & mem_write_raw;
    assign ir_write   = rst_n & ir_write_raw;
    assign pc_write   = rst_n & pc_write_raw;
    assign reg_write  = rst_n & reg_write_raw;
    assign instr_done = rst_n & instr_done_raw;

endmodule
